parking_timebase: RTL and testbench
===================================

# parking_timebase

Parametrised global time base for the parking system. It is the next generation of the fixed 8-bit, divide-by-4 time counter. It adds configurable width and prescale, a wrap or saturate mode, run/pause, synchronous clear and preset, and NUM_ALARMS one-shot compare channels. Slot, billing and gate controllers consume `time_value` and `tick`, and use the alarms for timeouts such as gate-open or grace-period expiry.

## Interface
Parameters:
- TIME_W, 8: width of `time_value`. Must be at least 2.
- PRESCALE, 4: enabled clock cycles per time increment. Must be at least 1.
- SATURATE, 0: selects the mode. 0 means wrap at max; 1 means hold at max.
- NUM_ALARMS, 4: number of compare channels. Must be at least 2. IDX_W = $clog2(NUM_ALARMS).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: run when 1, pause when 0. The prescaler holds while paused.
- clear, in, 1: synchronous clear of the time base.
- load, in, 1: synchronous preset of `time_value` from `load_value`.
- load_value, in, TIME_W: preset value.
- alarm_wr, in, 1: write strobe for alarm channel `alarm_idx`.
- alarm_idx, in, IDX_W: channel select. Writes with an index of NUM_ALARMS or above are ignored.
- alarm_value, in, TIME_W: compare value to write.
- alarm_arm, in, 1: written together with the value. 1 arms the channel; 0 disarms it.
- time_value, out, TIME_W: current time.
- tick, out, 1: one-cycle pulse on every prescaler rollover.
- wrapped, out, 1: one-cycle pulse when `time_value` rolls from max to 0 (wrap mode only).
- saturated, out, 1: level. Set while `time_value` is held at max in saturate mode.
- alarm_armed, out, NUM_ALARMS: per-channel armed state.
- alarm_fire, out, NUM_ALARMS: per-channel one-cycle fire pulse.

## Operation
**Prescaler**
- Width is max(1, $clog2(PRESCALE)).
- Counts 0 to PRESCALE-1 only on cycles with `enable`=1.
- On reaching PRESCALE-1 with `enable`=1 it returns to 0 and produces a rollover.
- With PRESCALE=1, every enabled cycle is a rollover.

**Counting on a rollover**
- `tick` is asserted.
- If `time_value` is below max, it increments.
- At max in wrap mode, `time_value` goes to 0 and `wrapped` pulses.
- At max in saturate mode, `time_value` holds, `saturated`=1, and `tick` still pulses.

**Priority, per cycle:** `clear` > `load` > count.
- `clear`: `time_value`=0, prescaler=0, `saturated`=0. No `tick`, no `wrapped`, no alarm evaluation. Alarm registers are untouched.
- `load`: `time_value`=`load_value`, prescaler=0, no `tick`. `saturated` = SATURATE && (`load_value`==max).

**Update event.** An update is either:
- a `load`, or
- a counting rollover that changes `time_value`.

A saturated hold is not an update.

**Alarm channel i**
- Holds a value register and an armed bit.
- On an update where the new `time_value` equals `alarm_value[i]` and channel i is armed:
  - `alarm_fire[i]` pulses;
  - `alarm_armed[i]` clears (one-shot).
- Several channels may fire in the same cycle.
- An alarm write to channel i in the same cycle as a match on i: the write wins and channel i does not fire. Other channels are evaluated normally.
- An alarm armed at the current `time_value` does not fire until that value is reached again through a later update.

## Timing
- All outputs are registered.
- Reset values: `time_value`=0, prescaler=0, `tick`=0, `wrapped`=0, `saturated`=0, `alarm_armed`=0, `alarm_fire`=0, all alarm values=0.
- First `tick` and first `time_value`=1 appear at the clock edge ending the PRESCALE-th enabled cycle after reset deasserts.
- `tick`, `wrapped` and `alarm_fire` are asserted in the same cycle that `time_value` shows its new value.
- An alarm write takes effect at the next edge. `alarm_armed` reflects it one cycle after `alarm_wr`.
- `load` and `clear` results are visible on the cycle after the strobe.
- Reset asserted mid-count or mid-alarm returns everything to reset values immediately. No pulse survives reset.

## Structure
- Shared package `parking_pkg` holds:
  - TIME_MODE_WRAP=0 and TIME_MODE_SAT=1 constants;
  - the default time width, so that billing and slot blocks share it.
- Sub-module `time_alarm_channel` (one per channel, instantiated by a generate loop) contains:
  - value register and armed bit;
  - write decode compare;
  - match-on-update logic;
  - the fire register.
- The top level holds the prescaler, the time register, mode logic and the alarm fan-out.

## Test plan
- **Reset and prescale:** TIME_W=8, PRESCALE=4, `enable`=1 for 40 cycles. Expect `tick` every 4th cycle, `time_value`=10, `wrapped`=0.
- **Pause and PRESCALE=1:** drop `enable` for 5 cycles mid-count. Expect the prescaler and `time_value` frozen and no `tick`. Repeat with PRESCALE=1 and expect +1 every enabled cycle.
- **Wrap vs saturate:** load 254 and run.
  - SATURATE=0: expect 255, then 0 with a `wrapped` pulse.
  - SATURATE=1: expect a hold at 255, `saturated`=1, `tick` continuing, no `wrapped`. A subsequent `clear` gives 0 and `saturated`=0.
- **Priority:** `clear` and `load`=50 in the same cycle gives `time_value`=0. `load`=50 alone gives 50 and a restarted prescaler (next `tick` 4 enabled cycles later).
- **Alarms:**
  - Arm ch0=5 and ch1=5, run from 0. Expect both to fire in the cycle `time_value`=5, then `alarm_armed`=0, with no re-fire after a wrap.
  - `load`=20 with ch2 armed at 20 fires ch2.
- **Alarm edge cases:**
  - A write to ch3 coinciding with its match gives no fire.
  - An alarm armed at the current value fires only on the next arrival.
  - Reset asserted one cycle before a match gives no `alarm_fire`.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared constants for the parking system time base.
// Billing and slot blocks import the default time width from here.
package parking_pkg;

    localparam int TIME_MODE_WRAP = 0;
    localparam int TIME_MODE_SAT  = 1;
    localparam int TIME_W_DEFAULT = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/time_alarm_channel.sv
// One-shot compare channel: value/armed registers, write decode,
// match-on-update and the registered fire pulse.
module time_alarm_channel
    import parking_pkg::*;
#(
    parameter int TIME_W = TIME_W_DEFAULT,
    parameter int IDX_W  = 2,
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TIME_W-1:0] wr_value,
    input  logic              wr_arm,
    input  logic              update,
    input  logic [TIME_W-1:0] new_time,
    output logic              armed,
    output logic              fire
);

    logic [TIME_W-1:0] value;
    logic              sel;
    logic              hit;

    assign sel = wr && (idx == IDX_W'(IDX));
    assign hit = update && armed && (new_time == value);

    // A write to this channel wins over a coincident match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
            armed <= 1'b0;
            fire  <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (sel) begin
                value <= wr_value;
                armed <= wr_arm;
            end else if (hit) begin
                fire  <= 1'b1;
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/parking_timebase.sv
// Global time base: prescaler, wrap/saturate time register,
// clear/load preset and NUM_ALARMS one-shot compare channels.
module parking_timebase
    import parking_pkg::*;
#(
    parameter int TIME_W     = TIME_W_DEFAULT,
    parameter int PRESCALE   = 4,
    parameter int SATURATE   = TIME_MODE_WRAP,
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = $clog2(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic [TIME_W-1:0]     load_value,
    input  logic                  alarm_wr,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic [TIME_W-1:0]     alarm_value,
    input  logic                  alarm_arm,
    output logic [TIME_W-1:0]     time_value,
    output logic                  tick,
    output logic                  wrapped,
    output logic                  saturated,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output logic [NUM_ALARMS-1:0] alarm_fire
);

    localparam int PS_W = max_int(1, $clog2(PRESCALE));
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [TIME_W-1:0] TMAX = '1;
    localparam logic SAT_MODE = (SATURATE == TIME_MODE_SAT);

    logic [PS_W-1:0]   pcnt;
    logic [TIME_W-1:0] nxt_time;
    logic              roll;
    logic              at_max;
    logic              upd;
    logic              count;

    assign roll   = enable && (pcnt == PS_LAST);
    assign at_max = (time_value == TMAX);
    assign count  = roll && !clear && !load;

    // Next time and update event; a saturated hold is not an update.
    always_comb begin
        nxt_time = time_value;
        upd      = 1'b0;
        if (clear) begin
            nxt_time = '0;
        end else if (load) begin
            nxt_time = load_value;
            upd      = 1'b1;
        end else if (roll && !(at_max && SAT_MODE)) begin
            nxt_time = time_value + 1'b1;
            upd      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt       <= '0;
            time_value <= '0;
            tick       <= 1'b0;
            wrapped    <= 1'b0;
            saturated  <= 1'b0;
        end else begin
            time_value <= nxt_time;
            tick       <= count;
            wrapped    <= count && at_max && !SAT_MODE;
            if (clear || load || roll) begin
                pcnt <= '0;
            end else if (enable) begin
                pcnt <= pcnt + 1'b1;
            end
            if (clear) begin
                saturated <= 1'b0;
            end else if (load) begin
                saturated <= SAT_MODE && (load_value == TMAX);
            end else if (roll && at_max && SAT_MODE) begin
                saturated <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
        time_alarm_channel #(
            .TIME_W (TIME_W),
            .IDX_W  (IDX_W),
            .IDX    (i)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .wr       (alarm_wr),
            .idx      (alarm_idx),
            .wr_value (alarm_value),
            .wr_arm   (alarm_arm),
            .update   (upd),
            .new_time (nxt_time),
            .armed    (alarm_armed[i]),
            .fire     (alarm_fire[i])
        );
    end

endmodule

// File: tb/tb_parking_timebase.sv
// Bench for parking_timebase: three configurations (wrap/4, sat/4, wrap/1)
// share one stimulus and are each checked against a behavioural model.
module tb_parking_timebase;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       alarm_wr = 1'b0;
    logic [1:0] alarm_idx = '0;
    logic [7:0] alarm_value = '0;
    logic       alarm_arm = 1'b0;

    logic [2:0][7:0] tv;
    logic [2:0]      tk;
    logic [2:0]      wr_o;
    logic [2:0]      sat_o;
    logic [2:0][3:0] arm_o;
    logic [2:0][3:0] fo;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    parking_timebase #(.TIME_W(8), .PRESCALE(4), .SATURATE(0), .NUM_ALARMS(4)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
        .alarm_value(alarm_value), .alarm_arm(alarm_arm), .time_value(tv[0]),
        .tick(tk[0]), .wrapped(wr_o[0]), .saturated(sat_o[0]),
        .alarm_armed(arm_o[0]), .alarm_fire(fo[0]));

    parking_timebase #(.TIME_W(8), .PRESCALE(4), .SATURATE(1), .NUM_ALARMS(4)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
        .alarm_value(alarm_value), .alarm_arm(alarm_arm), .time_value(tv[1]),
        .tick(tk[1]), .wrapped(wr_o[1]), .saturated(sat_o[1]),
        .alarm_armed(arm_o[1]), .alarm_fire(fo[1]));

    parking_timebase #(.TIME_W(8), .PRESCALE(1), .SATURATE(0), .NUM_ALARMS(4)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
        .alarm_value(alarm_value), .alarm_arm(alarm_arm), .time_value(tv[2]),
        .tick(tk[2]), .wrapped(wr_o[2]), .saturated(sat_o[2]),
        .alarm_armed(arm_o[2]), .alarm_fire(fo[2]));

    function automatic int ps_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit sat_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    endtask

    // Behavioural model: time in whole increments, phase = enabled cycles
    // since the last restart, alarms as plain value/armed tables.
    int         m_t [3] = '{0, 0, 0};
    int         m_ph[3] = '{0, 0, 0};
    int         m_val[3][4];
    logic [3:0] m_arm[3] = '{4'h0, 4'h0, 4'h0};
    logic       e_tk [3] = '{1'b0, 1'b0, 1'b0};
    logic       e_wr [3] = '{1'b0, 1'b0, 1'b0};
    logic       e_sat[3] = '{1'b0, 1'b0, 1'b0};
    logic [3:0] e_fire[3] = '{4'h0, 4'h0, 4'h0};

    always @(posedge clk or posedge reset) begin
        logic upd;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_t[k] = 0; m_ph[k] = 0; m_arm[k] = '0;
                e_tk[k] = 0; e_wr[k] = 0; e_sat[k] = 0; e_fire[k] = '0;
                for (int i = 0; i < 4; i++) m_val[k][i] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                upd = 0;
                e_tk[k] = 0; e_wr[k] = 0; e_fire[k] = '0;
                if (clear) begin
                    m_t[k] = 0; m_ph[k] = 0; e_sat[k] = 0;
                end else if (load) begin
                    m_t[k] = int'(load_value); m_ph[k] = 0; upd = 1;
                    e_sat[k] = sat_of(k) && (load_value == 8'd255);
                end else if (enable) begin
                    m_ph[k]++;
                    if (m_ph[k] == ps_of(k)) begin
                        m_ph[k] = 0;
                        e_tk[k] = 1;
                        if (m_t[k] < 255) begin
                            m_t[k]++; upd = 1;
                        end else if (sat_of(k)) begin
                            e_sat[k] = 1;
                        end else begin
                            m_t[k] = 0; e_wr[k] = 1; upd = 1;
                        end
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (alarm_wr && alarm_idx == 2'(i)) begin
                        m_val[k][i] = int'(alarm_value);
                        m_arm[k][i] = alarm_arm;
                    end else if (upd && m_arm[k][i] && m_val[k][i] == m_t[k]) begin
                        e_fire[k][i] = 1;
                        m_arm[k][i] = 0;
                    end
                end
            end
        end
    end

    logic       seen_fire = 1'b0;
    logic [3:0] seen_mask = '0;
    logic [7:0] seen_time = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cycle_dut%0d", k),
                {13'd0, tv[k], tk[k], wr_o[k], sat_o[k], arm_o[k], fo[k]},
                {13'd0, 8'(m_t[k]), e_tk[k], e_wr[k], e_sat[k], m_arm[k], e_fire[k]});
        end
        if (!seen_fire && fo[0] != 4'h0) begin
            seen_fire = 1'b1;
            seen_mask = fo[0];
            seen_time = tv[0];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic awrite(input logic [1:0] idx, input logic [7:0] v, input logic a);
        alarm_wr = 1'b1; alarm_idx = idx; alarm_value = v; alarm_arm = a;
        cyc();
        alarm_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(); cyc();
        chk("rst_time", 32'(tv[0]), 32'd0);
        chk("rst_armed", 32'(arm_o[0]), 32'd0);
        reset = 1'b0;

        awrite(2'd0, 8'd5, 1'b1);
        awrite(2'd1, 8'd5, 1'b1);
        chk("armed01", 32'(arm_o[0]), 32'h3);

        enable = 1'b1;
        repeat (40) cyc();
        chk("run40_a", 32'(tv[0]), 32'd10);
        chk("run40_b", 32'(tv[1]), 32'd10);
        chk("run40_c", 32'(tv[2]), 32'd40);
        chk("run40_wrapped", 32'(wr_o[0]), 32'd0);
        chk("run40_armed", 32'(arm_o[0]), 32'd0);
        chk("fire_mask", 32'(seen_mask), 32'h3);
        chk("fire_time", 32'(seen_time), 32'd5);

        repeat (2) cyc();
        enable = 1'b0;
        repeat (5) cyc();
        chk("pause_a", 32'(tv[0]), 32'd10);
        chk("pause_c", 32'(tv[2]), 32'd42);
        enable = 1'b1;
        repeat (2) cyc();
        chk("resume_a", 32'(tv[0]), 32'd11);
        chk("resume_tick", 32'(tk[0]), 32'd1);
        chk("resume_c", 32'(tv[2]), 32'd44);

        load = 1'b1; load_value = 8'd254;
        cyc();
        load = 1'b0;
        chk("load254", 32'(tv[0]), 32'd254);
        repeat (4) cyc();
        chk("wrap_255", 32'(tv[0]), 32'd255);
        chk("sat_255", 32'(tv[1]), 32'd255);
        chk("sat_not_yet", 32'(sat_o[1]), 32'd0);
        repeat (4) cyc();
        chk("wrap_0", 32'(tv[0]), 32'd0);
        chk("wrap_pulse", 32'(wr_o[0]), 32'd1);
        chk("sat_hold", 32'(tv[1]), 32'd255);
        chk("sat_level", 32'(sat_o[1]), 32'd1);
        chk("sat_tick", 32'(tk[1]), 32'd1);
        chk("sat_nowrap", 32'(wr_o[1]), 32'd0);

        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_b_time", 32'(tv[1]), 32'd0);
        chk("clr_b_sat", 32'(sat_o[1]), 32'd0);

        clear = 1'b1; load = 1'b1; load_value = 8'd50;
        cyc();
        clear = 1'b0;
        chk("prio_clear", 32'(tv[0]), 32'd0);
        cyc();
        load = 1'b0;
        chk("prio_load", 32'(tv[0]), 32'd50);
        repeat (3) cyc();
        chk("restart_hold", 32'(tv[0]), 32'd50);
        cyc();
        chk("restart_inc", 32'(tv[0]), 32'd51);
        chk("restart_tick", 32'(tk[0]), 32'd1);

        enable = 1'b0;
        awrite(2'd2, 8'd20, 1'b1);
        load = 1'b1; load_value = 8'd20;
        cyc();
        load = 1'b0;
        chk("load_fire2", 32'(fo[0]), 32'h4);
        chk("load_fire2_armed", 32'(arm_o[0]), 32'h0);

        awrite(2'd3, 8'd30, 1'b1);
        load = 1'b1; load_value = 8'd30;
        alarm_wr = 1'b1; alarm_idx = 2'd3; alarm_value = 8'd30; alarm_arm = 1'b1;
        cyc();
        load = 1'b0; alarm_wr = 1'b0;
        chk("wr_wins_fire", 32'(fo[0]), 32'h0);
        chk("wr_wins_armed", 32'(arm_o[0]), 32'h8);
        enable = 1'b1;
        repeat (4) cyc();
        chk("armed_at_cur", 32'(tv[0]), 32'd31);
        enable = 1'b0;
        load = 1'b1; load_value = 8'd30;
        cyc();
        load = 1'b0;
        chk("next_arrival", 32'(fo[0]), 32'h8);

        awrite(2'd0, 8'd40, 1'b1);
        load = 1'b1; load_value = 8'd39;
        cyc();
        load = 1'b0;
        enable = 1'b1;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_fire", 32'(fo[0]), 32'h0);
        chk("rst_time2", 32'(tv[0]), 32'd0);
        chk("rst_armed2", 32'(arm_o[0]), 32'h0);
        reset = 1'b0; enable = 1'b0;
        cyc();
        chk("post_rst", 32'(tv[0]), 32'd0);

        cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
